// File: rtl/vga_bar_pkg.sv
// Shared types, default colours and the sample-to-height helper for the bar-graph renderer.
package vga_bar_pkg;

    typedef logic [11:0] rgb444_t;

    // Bar heights are stored as pixel rows, so they share the coordinate width.
    localparam int HW = 10;

    localparam rgb444_t COL_CH0 = 12'h00A;
    localparam rgb444_t COL_CH1 = 12'h0A0;
    localparam rgb444_t COL_REF = 12'hA00;
    localparam rgb444_t COL_BG  = 12'h000;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Height = (sample*mul)>>shift, clamped to the baseline after the shift.
    // The 64-bit product cannot overflow for any sample width up to 32 bits.
    function automatic logic [HW-1:0] scale_clamp(input logic [31:0] sample,
                                                  input int mul, input int shift,
                                                  input int base);
        logic [63:0] prod;
        prod = 64'(sample) * 64'(mul);
        prod = prod >> shift;
        if (prod > 64'(base)) prod = 64'(base);
        return prod[HW-1:0];
    endfunction

endpackage

// File: rtl/vga_bar_ring.sv
// History ring: DEPTH snapshots of NCH heights, newest addressed by column offset 0.
module vga_bar_ring
    import vga_bar_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int NCH   = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic                clr_i,
    input  logic [NCH*HW-1:0]   wdata_i,
    input  logic [9:0]          rd_col_i,
    output logic [NCH*HW-1:0]   rd_data_o,
    output logic                rd_vis_o
);
    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    logic [NCH*HW-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW:0]       cnt_q;
    logic [AW-1:0]     rd_addr;
    logic [NCH*HW-1:0] rd_data_q;
    logic              rd_vis_q;

    // Column k shows the entry written k pushes before the newest one.
    assign rd_addr = wr_ptr_q - AW'(1) - rd_col_i[AW-1:0];

    // Write pointer and occupancy; clear wins over a same-cycle push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (push_i) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (cnt_q != (AW+1)'(DEPTH)) cnt_q <= cnt_q + (AW+1)'(1);
        end
    end

    // Storage is never cleared; occupancy alone decides what is shown.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Registered read; a same-cycle write to the address returns the old word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
            rd_vis_q  <= 1'b0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
            rd_vis_q  <= (32'(rd_col_i) < 32'(cnt_q));
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_vis_o  = rd_vis_q;

endmodule

// File: rtl/vga_bar_graph.sv
// Scrolling multi-channel bar graph: sample latch, frame-paced history push, 3-stage pixel pipe.
module vga_bar_graph
    import vga_bar_pkg::*;
#(
    parameter int                  DW          = 12,
    parameter int                  NCH         = 2,
    parameter int                  DEPTH       = 32,
    parameter int                  COL_W       = 20,
    parameter int                  BASE_Y      = 400,
    parameter int                  REF_Y       = 120,
    parameter int                  SCALE_MUL   = 1,
    parameter int                  SCALE_SHIFT = 4,
    parameter int                  UPD_FRAMES  = 60,
    parameter logic [NCH*12-1:0]   CH_COLORS   = {COL_CH1, COL_CH0},
    parameter rgb444_t             REF_COLOR   = COL_REF,
    parameter rgb444_t             BG_COLOR    = COL_BG,
    localparam int                 CW          = (NCH > 1) ? clog2(NCH) : 1
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [9:0]    iVGA_X,
    input  logic [9:0]    iVGA_Y,
    input  logic          iFrame,
    input  logic [DW-1:0] iD,
    input  logic [CW-1:0] iD_ch,
    input  logic          iD_valid,
    input  logic          iHold,
    input  logic          iClr,
    output logic [3:0]    oRed,
    output logic [3:0]    oGreen,
    output logic [3:0]    oBlue
);
    localparam int FW = (clog2(UPD_FRAMES) < 1) ? 1 : clog2(UPD_FRAMES);

    logic [DW-1:0]     lat_q [NCH];
    logic [FW-1:0]     fcnt_q;
    logic              push_q;
    logic [NCH*HW-1:0] wdata;
    logic [9:0]        col_q, y1_q, y2_q;
    logic [NCH*HW-1:0] rd_data;
    logic              rd_vis;
    logic [HW-1:0]     h3;
    rgb444_t           pix_d, rgb_q;

    // Newest sample per channel; out-of-range channel ids are dropped.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int c = 0; c < NCH; c++) lat_q[c] <= '0;
        end else if (iD_valid && (32'(iD_ch) < 32'(NCH))) begin
            lat_q[iD_ch] <= iD;
        end
    end

    // Frame pacing: the wrapping frame pulse schedules a push for the next cycle.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            fcnt_q <= '0;
            push_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (iClr) begin
                fcnt_q <= '0;
            end else if (iFrame && !iHold) begin
                if (fcnt_q == FW'(UPD_FRAMES - 1)) begin
                    fcnt_q <= '0;
                    push_q <= 1'b1;
                end else begin
                    fcnt_q <= fcnt_q + FW'(1);
                end
            end
        end
    end

    // Snapshot of scaled heights taken from the latch as it stands in the write cycle.
    always_comb begin
        wdata = '0;
        for (int c = 0; c < NCH; c++)
            wdata[c*HW +: HW] = scale_clamp(32'(lat_q[c]), SCALE_MUL, SCALE_SHIFT, BASE_Y);
    end

    vga_bar_ring #(.DEPTH(DEPTH), .NCH(NCH)) u_ring (
        .clk_i     (iCLK),
        .rst_i     (iRST),
        .push_i    (push_q && !iHold),
        .clr_i     (iClr),
        .wdata_i   (wdata),
        .rd_col_i  (col_q),
        .rd_data_o (rd_data),
        .rd_vis_o  (rd_vis)
    );

    // S1 column index and row, S2 row alongside the ring read.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            col_q <= '0;
            y1_q  <= '0;
            y2_q  <= '0;
        end else begin
            col_q <= iVGA_X / 10'(COL_W);
            y1_q  <= iVGA_Y;
            y2_q  <= y1_q;
        end
    end

    // S3 colour select: reference line, then lowest lit channel, then background.
    always_comb begin
        pix_d = BG_COLOR;
        h3    = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            h3 = rd_data[c*HW +: HW];
            if (rd_vis && (y2_q < 10'(BASE_Y)) && (11'(y2_q) + 11'(h3) >= 11'(BASE_Y)))
                pix_d = CH_COLORS[c*12 +: 12];
        end
        if (y2_q == 10'(REF_Y)) pix_d = REF_COLOR;
    end

    // Output register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) rgb_q <= '0;
        else      rgb_q <= pix_d;
    end

    assign oRed   = rgb_q[11:8];
    assign oGreen = rgb_q[7:4];
    assign oBlue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_bar_graph.sv
// Bench for vga_bar_graph: history model as a queue of snapshots, pixel scoreboard with a 3-cycle due time.
module tb_vga_bar_graph;

    localparam int DW = 12, NCH = 3, DEPTH = 8, COL_W = 20, BASE_Y = 400, REF_Y = 120;
    localparam int MUL = 5, SH = 4, UPD = 5;
    localparam logic [11:0] C0 = 12'h00A, C1 = 12'h0A0, C2 = 12'hFF0, CREF = 12'hA00, CBG = 12'h000;
    localparam logic [35:0] CHP = {C2, C1, C0};

    typedef logic [NCH-1:0][DW-1:0] snap_t;
    typedef struct { int due; int x; int y; logic [11:0] exp; } chk_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic [9:0]    vx = '0, vy = '0;
    logic          frm = 1'b0, dv = 1'b0, hold = 1'b0, clr = 1'b0;
    logic [DW-1:0] d = '0;
    logic [1:0]    dch = '0;
    logic [3:0]    r, g, b;

    int    errs = 0, checks = 0, cyc = 0;
    chk_t  sbq[$];
    snap_t hist[$];
    snap_t lat = '0;
    int    fcnt = 0;

    vga_bar_graph #(
        .DW(DW), .NCH(NCH), .DEPTH(DEPTH), .COL_W(COL_W), .BASE_Y(BASE_Y), .REF_Y(REF_Y),
        .SCALE_MUL(MUL), .SCALE_SHIFT(SH), .UPD_FRAMES(UPD), .CH_COLORS(CHP),
        .REF_COLOR(CREF), .BG_COLOR(CBG)
    ) dut (
        .iCLK(clk), .iRST(rst), .iVGA_X(vx), .iVGA_Y(vy), .iFrame(frm),
        .iD(d), .iD_ch(dch), .iD_valid(dv), .iHold(hold), .iClr(clr),
        .oRed(r), .oGreen(g), .oBlue(b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic int h_of(input logic [DW-1:0] v);
        int h;
        h = (int'(v) * MUL) >> SH;
        return (h > BASE_Y) ? BASE_Y : h;
    endfunction

    function automatic logic [11:0] ch_col(input int c);
        case (c)
            0:       return C0;
            1:       return C1;
            default: return C2;
        endcase
    endfunction

    function automatic logic [11:0] exp_pix(input int x, input int y);
        int k;
        snap_t s;
        if (y == REF_Y) return CREF;
        k = x / COL_W;
        if (k >= hist.size()) return CBG;
        s = hist[k];
        for (int c = 0; c < NCH; c++)
            if (y < BASE_Y && y >= BASE_Y - h_of(s[c])) return ch_col(c);
        return CBG;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        chk_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            checks++;
            if (e.due != cyc || {r, g, b} !== e.exp) begin
                errs++;
                $display("FAIL pix x=%0d y=%0d got=%h want=%h (due %0d at %0d)",
                         e.x, e.y, {r, g, b}, e.exp, e.due, cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic pix(input int x, input int y);
        chk_t e;
        vx = 10'(x);
        vy = 10'(y);
        e.due = cyc + 3;
        e.x   = x;
        e.y   = y;
        e.exp = exp_pix(x, y);
        sbq.push_back(e);
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (sbq.size() > 0) begin
            errs++;
            $display("FAIL drain: %0d pixels never compared", sbq.size());
            sbq.delete();
        end
        tick();
    endtask

    task automatic send(input int c, input int v);
        d   = DW'(v);
        dch = 2'(c);
        dv  = 1'b1;
        tick();
        dv  = 1'b0;
        if (c < NCH) lat[c] = DW'(v);
    endtask

    // Frame pulse cycle, then the cycle in which any push is written (optional sample there).
    task automatic frame(input bit c, input bit wd, input int dc, input int dval);
        bit p;
        p   = 1'b0;
        frm = 1'b1;
        clr = c;
        tick();
        frm = 1'b0;
        clr = 1'b0;
        if (c) begin
            fcnt = 0;
            hist.delete();
        end else if (!hold) begin
            if (fcnt == UPD - 1) begin
                fcnt = 0;
                p = 1'b1;
            end else begin
                fcnt++;
            end
        end
        if (p) begin
            hist.push_front(lat);
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
        if (wd) begin
            d   = DW'(dval);
            dch = 2'(dc);
            dv  = 1'b1;
            if (dc < NCH) lat[dc] = DW'(dval);
        end
        tick();
        dv = 1'b0;
    endtask

    task automatic scan_col(input int k);
        int x;
        int rows[$];
        snap_t s;
        x = k * COL_W + int'($urandom_range(0, COL_W - 1));
        rows = '{0, 119, 120, 121, 399, 400, 401};
        if (k < hist.size()) begin
            s = hist[k];
            for (int c = 0; c < NCH; c++) begin
                rows.push_back(BASE_Y - h_of(s[c]) - 1);
                rows.push_back(BASE_Y - h_of(s[c]));
            end
        end
        foreach (rows[i]) if (rows[i] >= 0) pix(x, rows[i]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #1;
        chk("reset_out_t0", {r, g, b}, 12'h000);
        repeat (3) tick();
        chk("reset_out_held", {r, g, b}, 12'h000);
        rst = 1'b0;

        // Empty history: only the reference row lights, exactly 3 cycles after its coordinates.
        pix(5, 118); pix(5, 119); pix(5, 120); pix(5, 121); pix(600, 120); pix(600, 300); pix(1023, 1023);
        drain();

        // Single push with known heights (100, 50, 0); channel 3 does not exist.
        send(0, 320); send(1, 160); send(2, 0); send(3, 4095);
        repeat (UPD - 1) frame(1'b0, 1'b0, 0, 0);
        scan_col(0);
        frame(1'b0, 1'b0, 0, 0);
        scan_col(0); scan_col(1);
        pix(5, 299); pix(5, 300); pix(5, 349); pix(5, 350); pix(5, 399); pix(5, 400); pix(25, 350);
        drain();

        // Hold freezes pushes while the latch keeps updating.
        hold = 1'b1;
        send(1, 1000);
        repeat (3 * UPD) frame(1'b0, 1'b0, 0, 0);
        scan_col(0); scan_col(1);
        hold = 1'b0;
        drain();
        repeat (UPD) frame(1'b0, 1'b0, 0, 0);
        scan_col(0); scan_col(1); scan_col(2);
        drain();

        // Clamp to the baseline: full-height bar.
        send(0, 4095);
        repeat (UPD) frame(1'b0, 1'b0, 0, 0);
        scan_col(0);
        pix(5, 0); pix(5, 1);
        drain();

        // Clear on the wrapping frame drops the push and empties the display.
        repeat (UPD - 1) frame(1'b0, 1'b0, 0, 0);
        frame(1'b1, 1'b0, 0, 0);
        scan_col(0); scan_col(1);
        drain();
        repeat (UPD - 1) frame(1'b0, 1'b0, 0, 0);
        scan_col(0);
        frame(1'b0, 1'b0, 0, 0);
        scan_col(0); scan_col(1);
        drain();

        // Sample arriving in the push cycle lands in the following snapshot, not this one.
        send(0, 200);
        repeat (UPD - 1) frame(1'b0, 1'b0, 0, 0);
        frame(1'b0, 1'b1, 0, 777);
        scan_col(0);
        drain();
        repeat (UPD) frame(1'b0, 1'b0, 0, 0);
        scan_col(0); scan_col(1);
        drain();

        // Ring wrap: 12 pushes into 8 entries, heights 5*i on channel 0.
        for (int i = 1; i <= 12; i++) begin
            send(0, 16 * i);
            repeat (UPD) frame(1'b0, 1'b0, 0, 0);
        end
        for (int k = 0; k <= DEPTH; k++) scan_col(k);
        pix(159, 399); pix(160, 399); pix(639, 399); pix(1000, 399);
        drain();

        // Randomised rounds.
        for (int rd = 0; rd < 25; rd++) begin
            repeat ($urandom_range(0, 4)) send(int'($urandom_range(0, 3)), int'($urandom_range(0, 1400)));
            hold = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 12))
                frame($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 1400)));
            hold = 1'b0;
            for (int i = 0; i < 30; i++) begin
                int x, y;
                x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 179));
                y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(100, 420));
                pix(x, y);
            end
            scan_col(int'($urandom_range(0, DEPTH - 1)));
            drain();
        end

        // Asynchronous reset mid-run clears latch, pacing and history.
        #2 rst = 1'b1;
        #1 chk("reset_out_async", {r, g, b}, 12'h000);
        tick(); tick();
        chk("reset_out_mid", {r, g, b}, 12'h000);
        rst  = 1'b0;
        lat  = '0;
        fcnt = 0;
        hist.delete();
        scan_col(0);
        send(0, 500);
        repeat (UPD) frame(1'b0, 1'b0, 0, 0);
        scan_col(0); scan_col(1);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
